// File: rtl/fp_norm_round_pkg.sv
// Shared widths and the stage-1-to-stage-2 beat format for fp_norm_round.
// Contents:
//   C_EXP, C_MANT                 - IEEE-754 exponent / stored mantissa widths
//   C_EXP_PRENORM, C_MANT_PRENORM - prenorm exponent / mantissa widths
//   C_BIAS                        - exponent bias
//   norm_t                        - normalized beat handed from stage 1 to stage 2
package fp_defs;

    localparam int unsigned C_EXP          = 8;
    localparam int unsigned C_MANT         = 23;
    localparam int unsigned C_EXP_PRENORM  = 10;
    localparam int unsigned C_MANT_PRENORM = 48;
    localparam int unsigned C_BIAS         = 127;

    // Normalized exponent carries one extra bit so +1 / -46 cannot wrap.
    localparam int unsigned C_EXP_NORM  = C_EXP_PRENORM + 1;
    // After normalization the carry position is always clear, so only
    // hidden bit and below are kept.
    localparam int unsigned C_MANT_NORM = C_MANT_PRENORM - 1;
    localparam int unsigned C_LZC_CNT_W = $clog2(C_MANT_NORM);

    // Bit positions inside the normalized mantissa (hidden bit at the MSB).
    localparam int unsigned C_HIDDEN_POS = C_MANT_NORM - 1;
    localparam int unsigned C_LSB_POS    = C_HIDDEN_POS - C_MANT;
    localparam int unsigned C_GUARD_POS  = C_LSB_POS - 1;

    typedef struct packed {
        logic                          sign;
        logic signed [C_EXP_NORM-1:0]  exp;
        logic        [C_MANT_NORM-1:0] mant;
        logic                          sticky;
        logic                          is_zero;
    } norm_t;

endpackage

// File: rtl/fp_norm_round_lzc.sv
// Leading-zero counter.
// Ports:
//   data     - input vector, MSB is the first position counted
//   count    - number of zeros above the most significant set bit (0 if none set)
//   all_zero - high when data has no bit set
module fp_lzc #(
    parameter int unsigned WIDTH = 47,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scan upward so the highest set bit is the last assignment and wins.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign all_zero = ~|data;

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize-and-round unit producing packed IEEE-754 single results.
// Stage 1 normalizes the prenorm mantissa (carry shift or leading-zero shift),
// stage 2 rounds to nearest-even, detects overflow/underflow and packs.
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   valid_i / ready_o              - input handshake
//   Sign_prenorm_DI                - prenorm sign
//   Exp_prenorm_DI                 - prenorm exponent (signed)
//   Mant_prenorm_DI                - prenorm mantissa, bit 47 carry, bit 46 hidden
//   valid_o / ready_i              - output handshake
//   Result_DO                      - packed {sign, exponent, mantissa}
//   Overflow_SO, Underflow_SO,
//   Inexact_SO                     - exception flags, valid with valid_o
module fp_norm_round
    import fp_defs::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      Sign_prenorm_DI,
    input  logic [C_EXP_PRENORM-1:0]  Exp_prenorm_DI,
    input  logic [C_MANT_PRENORM-1:0] Mant_prenorm_DI,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [C_EXP+C_MANT:0]     Result_DO,
    output logic                      Overflow_SO,
    output logic                      Underflow_SO,
    output logic                      Inexact_SO
);

    localparam logic signed [C_EXP_NORM:0] EXP_MAX = (C_EXP_NORM+1)'((2 ** C_EXP) - 1);

    logic s1_valid, s2_valid;
    logic s1_load, s2_load;

    // ---------------- stage 1: normalize ----------------
    logic                         carry;
    logic [C_LZC_CNT_W-1:0]       lz_count;
    logic                         lz_zero;
    logic signed [C_EXP_NORM-1:0] exp_ext;
    norm_t                        s1_d, s1_q;

    assign carry   = Mant_prenorm_DI[C_MANT_PRENORM-1];
    assign exp_ext = {Exp_prenorm_DI[C_EXP_PRENORM-1], Exp_prenorm_DI};

    fp_lzc #(
        .WIDTH (C_MANT_NORM),
        .CNT_W (C_LZC_CNT_W)
    ) u_lzc (
        .data     (Mant_prenorm_DI[C_MANT_NORM-1:0]),
        .count    (lz_count),
        .all_zero (lz_zero)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = Sign_prenorm_DI;
        s1_d.is_zero = ~carry & lz_zero;
        if (carry) begin
            s1_d.mant   = Mant_prenorm_DI[C_MANT_PRENORM-1:1];
            s1_d.sticky = Mant_prenorm_DI[0];
            s1_d.exp    = exp_ext + C_EXP_NORM'(1);
        end else begin
            s1_d.mant   = Mant_prenorm_DI[C_MANT_NORM-1:0] << lz_count;
            s1_d.sticky = 1'b0;
            s1_d.exp    = exp_ext - C_EXP_NORM'(lz_count);
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [C_MANT-1:0]             stored;
    logic                          lsb, guard, sticky, round_up;
    logic [C_MANT:0]               mant_rnd;
    logic signed [C_EXP_NORM:0]    exp_fin;
    logic                          ovf_cond, unf_cond;
    logic [C_EXP+C_MANT:0]         res_d, res_q;
    logic                          ovf_d, unf_d, inx_d;
    logic                          ovf_q, unf_q, inx_q;

    assign stored   = s1_q.mant[C_HIDDEN_POS-1:C_LSB_POS];
    assign lsb      = s1_q.mant[C_LSB_POS];
    assign guard    = s1_q.mant[C_GUARD_POS];
    assign sticky   = (|s1_q.mant[C_GUARD_POS-1:0]) | s1_q.sticky;
    assign round_up = guard & (sticky | lsb);
    assign mant_rnd = {1'b0, stored} + (C_MANT+1)'(round_up);
    // Carry out of rounding leaves the stored field zero and bumps the exponent.
    assign exp_fin  = {s1_q.exp[C_EXP_NORM-1], s1_q.exp} + (C_EXP_NORM+1)'(mant_rnd[C_MANT]);
    assign ovf_cond = (exp_fin >= EXP_MAX);
    // Hidden bit set means the normalized mantissa is nonzero.
    assign unf_cond = (exp_fin[C_EXP_NORM] || (exp_fin == '0)) && s1_q.mant[C_HIDDEN_POS];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (s1_q.is_zero) begin
            res_d = '0;
        end else if (ovf_cond) begin
            res_d = {s1_q.sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (unf_cond) begin
            res_d = {s1_q.sign, {(C_EXP+C_MANT){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            res_d = {s1_q.sign, exp_fin[C_EXP-1:0], mant_rnd[C_MANT-1:0]};
            inx_d = guard | sticky;
        end
    end

    // ---------------- handshake ----------------
    assign s2_load = ~s2_valid | ready_i;
    assign s1_load = ~s1_valid | s2_load;
    assign ready_o = s1_load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) s1_valid <= valid_i;
            if (s2_load) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_load) s1_q <= s1_d;
        if (s2_load) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
        end
    end

    // Datapath registers are not reset; outputs read zero whenever no beat is held.
    assign valid_o      = s2_valid;
    assign Result_DO    = s2_valid ? res_q : '0;
    assign Overflow_SO  = s2_valid & ovf_q;
    assign Underflow_SO = s2_valid & unf_q;
    assign Inexact_SO   = s2_valid & inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
module tb_fp_norm_round;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        sign;
    logic [9:0]  expn;
    logic [47:0] mant;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] Result_DO;
    logic        Overflow_SO, Underflow_SO, Inexact_SO;

    always #5 clk_i = ~clk_i;

    fp_norm_round dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .Sign_prenorm_DI (sign),
        .Exp_prenorm_DI  (expn),
        .Mant_prenorm_DI (mant),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .Result_DO       (Result_DO),
        .Overflow_SO     (Overflow_SO),
        .Underflow_SO    (Underflow_SO),
        .Inexact_SO      (Inexact_SO)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf, inx;
    } exp_t;

    exp_t q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    // Drives one beat (valid_i left high) and returns just after the accepting edge.
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [31:0] r, input logic o, input logic u, input logic x);
        exp_t t;
        bit   ok;
        t.res = r; t.ovf = o; t.unf = u; t.inx = x;
        q.push_back(t);
        valid_i = 1'b1; sign = s; expn = e; mant = m;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (ready_o) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk_i);
        check("drain", 64'(q.size()), 64'd0);
        #1;
    endtask

    // Output monitor: scoreboard on handshake, stability while stalled.
    logic        held_v = 1'b0;
    logic [34:0] held;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 64'(valid_o), 64'd1);
                check("hold_data", 64'({Result_DO, Overflow_SO, Underflow_SO, Inexact_SO}), 64'(held));
            end
            if (valid_o && !ready_i) begin
                held_v = 1'b1;
                held   = {Result_DO, Overflow_SO, Underflow_SO, Inexact_SO};
            end else begin
                held_v = 1'b0;
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("result", 64'(Result_DO), 64'(e.res));
                    check("flags", 64'({Overflow_SO, Underflow_SO, Inexact_SO}),
                          64'({e.ovf, e.unf, e.inx}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        sign = 1'b0; expn = '0; mant = '0;
        repeat (2) @(posedge clk_i); #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        check("rst_result", 64'({Result_DO, Overflow_SO, Underflow_SO, Inexact_SO}), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Latency: 1.0 + 1.0 carry case
        send(1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 0, 0, 0);
        valid_i = 1'b0;
        @(negedge clk_i);
        check("latency_1", 64'(valid_o), 64'd0);
        @(negedge clk_i);
        check("latency_2", 64'(valid_o), 64'd1);
        drain();

        // Directed vectors, back-to-back at full throughput
        send(1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 0, 0, 1); // tie, LSB 0
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 0, 0, 1); // tie, LSB 1
        send(1'b1, 10'd0,   48'h0000_0000_0000, 32'h0000_0000, 0, 0, 0); // exact zero
        send(1'b0, 10'd10,  48'h0000_0000_0001, 32'h0000_0000, 0, 1, 1); // underflow
        send(1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 1, 0, 1); // overflow
        send(1'b0, 10'd142, 48'h0000_8000_0000, 32'h3F80_0000, 0, 0, 0); // lzc shift 15
        send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 0, 0, 1); // round carry-out
        send(1'b0, 10'd254, 48'h7FFF_FFC0_0000, 32'h7F80_0000, 1, 0, 1); // overflow via round
        send(1'b1, 10'd0,   48'h4000_0000_0000, 32'h8000_0000, 0, 1, 1); // exp 0 boundary
        send(1'b0, 10'd1,   48'h4000_0000_0000, 32'h0080_0000, 0, 0, 0); // smallest normal
        send(1'b0, 10'd127, 48'h8000_0000_0001, 32'h4000_0000, 0, 0, 1); // carry-shift sticky
        send(1'b0, 10'd127, 48'h8000_0080_0001, 32'h4000_0001, 0, 0, 1); // guard + sticky
        valid_i = 1'b0;
        drain();

        // Backpressure: 4 beats while ready_i is held low
        ready_i = 1'b0;
        fork
            begin
                send(1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 0, 0, 0);
                send(1'b0, 10'd128, 48'h4000_0000_0000, 32'h4000_0000, 0, 0, 0);
                send(1'b0, 10'd126, 48'h6000_0000_0000, 32'h3F40_0000, 0, 0, 0);
                send(1'b1, 10'd129, 48'h5000_0000_0000, 32'hC0A0_0000, 0, 0, 0);
                valid_i = 1'b0;
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk_i);
                    if (valid_o) begin seen = 1; break; end
                end
                check("bp_valid_seen", 64'(seen), 64'd1);
                check("bp_ready_low", 64'(ready_o), 64'd0);
                repeat (3) @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        ready_i = 1'b0;
        send(1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 0, 0, 0);
        send(1'b0, 10'd128, 48'h4000_0000_0000, 32'h4000_0000, 0, 0, 0);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_valid_o", 64'(valid_o), 64'd0);
        check("midrst_ready_o", 64'(ready_o), 64'd1);
        check("midrst_result", 64'({Result_DO, Overflow_SO, Underflow_SO, Inexact_SO}), 64'd0);
        q.delete();
        @(negedge clk_i); #3;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        repeat (8) @(posedge clk_i); #1;
        check("postrst_valid_o", 64'(valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 The block SHALL take parameters from package fp_defs: C_EXP (default 8, exponent width), C_MANT (default 23, stored mantissa width), C_EXP_PRENORM (default 10, signed prenorm exponent width), C_MANT_PRENORM (default 48, prenorm mantissa width).
REQ-002 The block SHALL expose the following ports:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- valid_i, in, 1: input beat valid.
- ready_o, out, 1: input accepted when high with valid_i.
- Sign_prenorm_DI, in, 1: prenorm sign.
- Exp_prenorm_DI, in, C_EXP_PRENORM, signed: prenorm exponent.
- Mant_prenorm_DI, in, C_MANT_PRENORM: prenorm mantissa; bit 47 is the carry position, bit 46 the hidden-bit position.
- valid_o, out, 1: result valid.
- ready_i, in, 1: downstream accepts.
- Result_DO, out, 1+C_EXP+C_MANT: packed IEEE-754 result.
- Overflow_SO, out, 1: result saturated to infinity.
- Underflow_SO, out, 1: result flushed to zero.
- Inexact_SO, out, 1: rounding discarded nonzero bits.

Function
REQ-003 The block SHALL be a 2-stage pipeline: stage 1 normalizes, stage 2 rounds and packs. Latency from an accepted input to valid_o is 2 cycles with no stall.
REQ-004 Each stage SHALL hold a valid flag. A stage loads when it is empty or its contents advance in the same cycle. ready_o = ~s1_valid | (~s2_valid | ready_i), so full throughput is 1 beat/cycle.
REQ-005 While valid_o=1 and ready_i=0, Result_DO and all flags SHALL stay stable. Accept and drain in the same cycle SHALL not lose or duplicate beats.
REQ-006 Stage 1, carry case: if mantissa bit 47=1, the mantissa SHALL be shifted right by 1 (the shifted-out bit ORed into sticky) and the exponent incremented by 1.
REQ-007 Stage 1, non-carry case: otherwise the block SHALL count leading zeros from bit 46 downward (count 0..46), shift the mantissa left by that count and subtract the count from the exponent. Exponent arithmetic is signed, width C_EXP_PRENORM+1.
REQ-008 Stage 1, zero mantissa: an all-zero mantissa SHALL mark the beat as exact zero and yield Result_DO = +0 (sign 0), with all flags 0.
REQ-009 Stage 2 bit fields, after normalization: stored mantissa = bits 45:23, LSB = bit 23, guard = bit 22, sticky = OR of bits 21:0 plus any sticky from REQ-006.
REQ-010 Rounding SHALL be round-to-nearest-even: round up iff guard & (sticky | LSB). Inexact_SO = guard | sticky.
REQ-011 Rounding carry-out SHALL zero the stored mantissa and increment the exponent.
REQ-012 Overflow: if the final exponent is >= 2^C_EXP-1, the result SHALL be {sign, all-ones exponent, zero mantissa} with Overflow_SO=1 and Inexact_SO=1.
REQ-013 Underflow: if the final exponent is <= 0 and the mantissa is nonzero, the result SHALL be {sign, 0, 0} with Underflow_SO=1 and Inexact_SO=1. Denormals are not produced.
REQ-014 Normal results SHALL be packed as {sign, exponent[C_EXP-1:0], stored mantissa}.

Reset
REQ-015 Asserting rst_ni low SHALL asynchronously clear both stage valid flags, so valid_o=0 and ready_o=1. Result_DO and the flags SHALL reset to 0.
REQ-016 A reset asserted mid-operation SHALL discard in-flight beats. No output is produced for them after reset releases.
REQ-017 Datapath registers MAY be non-reset, but outputs SHALL read 0 while valid_o=0 after reset.

Structure
REQ-018 Package fp_defs SHALL hold C_EXP, C_MANT, C_EXP_PRENORM, C_MANT_PRENORM, C_BIAS (127), and the stage-1-to-stage-2 struct typedef (sign, exp, mant, sticky, is_zero).
REQ-019 The leading-zero counter SHALL be a separate sub-module, fp_lzc, which is parameterized by width and outputs count and an all-zero flag.

Verification
REQ-020 Carry case (1.0+1.0): sign 0, exp 127, mant 48'h8000_0000_0000 -> 2 cycles later Result_DO=32'h4000_0000, all flags 0.
REQ-021 Rounding: mant 48'h4000_0040_0000, exp 127 (tie, LSB 0) -> 32'h3F80_0000 with Inexact_SO=1; mant 48'h4000_00C0_0000 (tie, LSB 1) -> 32'h3F80_0002 with Inexact_SO=1.
REQ-022 Zero and underflow: mant 0, sign 1 -> 32'h0000_0000 with flags 0; mant 48'h0000_0000_0001, exp 10 -> 32'h0000_0000 with Underflow_SO=1.
REQ-023 Overflow: exp 254, mant 48'h8000_0000_0000 -> 32'h7F80_0000 with Overflow_SO=1.
REQ-024 Backpressure: 4 back-to-back beats with ready_i held 0 for 3 cycles -> ready_o falls once both stages are full, outputs are held stable, and all 4 results emerge in order with none lost.
REQ-025 Reset: rst_ni pulsed low with 2 beats in flight -> valid_o=0 immediately, and no stale result appears after release.
